// File: rtl/pio_bank.sv
// pio_bank: multi-channel parallel I/O block on an Avalon-MM slave.
//
// Each channel has one output register, with atomic set/clear aliases, and
// one synchronised input port. Each input bit can capture rising and/or
// falling edges into a sticky write-1-to-clear register. A masked OR of the
// captures drives a registered level interrupt.
//
// Per-channel register map (word address = {channel, reg[2:0]}):
//   0 DATA (RO)     1 OUT (RW)        2 OUT_SET (WO)  3 OUT_CLR (WO)
//   4 EDGE_CAP (W1C) 5 IRQ_MASK (RW)  6 RISE_EN (RW)  7 FALL_EN (RW)
//
// Ports:
//   clk               single clock for all logic
//   reset_n           synchronous reset, active low
//   avs_address       word address {channel, reg}
//   avs_read          read strobe; data returned with a fixed latency of 1
//   avs_write         write strobe; takes effect on the sampling edge
//   avs_writedata     write data; bits above DATA_W are discarded
//   avs_readdata      read data; bits above DATA_W read 0
//   avs_readdatavalid high the cycle after an accepted read
//   irq               registered level interrupt
//   in_port           asynchronous inputs, channel c at [c*DATA_W +: DATA_W]
//   out_port          registered outputs, same packing
module pio_bank #(
    parameter int unsigned       NUM_CH      = 2,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] OUT_RESET   = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+2:0]  avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    output logic [31:0]                avs_readdata,
    output logic                       avs_readdatavalid,
    output logic                       irq,
    input  logic [NUM_CH*DATA_W-1:0]   in_port,
    output logic [NUM_CH*DATA_W-1:0]   out_port
);

    localparam int unsigned ADDR_W     = $clog2(NUM_CH) + 3;
    localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
    localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

    typedef enum logic [2:0] {
        REG_DATA = 3'd0,
        REG_OUT  = 3'd1,
        REG_SET  = 3'd2,
        REG_CLR  = 3'd3,
        REG_CAP  = 3'd4,
        REG_MASK = 3'd5,
        REG_RISE = 3'd6,
        REG_FALL = 3'd7
    } reg_e;

    typedef logic [DATA_W-1:0] word_t;

    word_t out_q  [NUM_CH];
    word_t out_d  [NUM_CH];
    word_t cap_q  [NUM_CH];
    word_t cap_d  [NUM_CH];
    word_t mask_q [NUM_CH];
    word_t mask_d [NUM_CH];
    word_t rise_q [NUM_CH];
    word_t rise_d [NUM_CH];
    word_t fall_q [NUM_CH];
    word_t fall_d [NUM_CH];

    word_t sync_q   [NUM_CH][SYNC_STAGES];
    word_t prev_q   [NUM_CH];
    word_t sync_out [NUM_CH];
    word_t det      [NUM_CH];

    logic [CNT_W-1:0]  settle_q;
    logic [CNT_W-1:0]  settle_d;
    logic              settle_done;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              rvalid_q;
    logic              irq_q;
    logic              irq_d;

    logic [ADDR_W-1:0] ch_sel;
    reg_e              reg_sel;
    word_t             wdata;

    // Channel indices at or above NUM_CH match no channel below, so such
    // reads return 0 and such writes are dropped.
    assign ch_sel      = avs_address >> 3;
    assign reg_sel     = reg_e'(avs_address[2:0]);
    assign wdata       = avs_writedata[DATA_W-1:0];
    assign settle_done = (settle_q == CNT_W'(SETTLE_MAX));

    // Edge detection stays gated until the synchronisers have flushed their
    // reset zeros, so inputs already high at reset release are not captured.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sync_out[c] = sync_q[c][SYNC_STAGES-1];
            det[c]      = '0;
            if (settle_done) begin
                det[c] = (sync_out[c] & ~prev_q[c] & rise_q[c]) |
                         (~sync_out[c] & prev_q[c] & fall_q[c]);
            end
        end
    end

    always_comb begin
        out_d    = out_q;
        cap_d    = cap_q;
        mask_d   = mask_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        rdata_d  = rdata_q;
        irq_d    = 1'b0;
        settle_d = settle_done ? settle_q : settle_q + CNT_W'(1);

        if (avs_read) begin
            rdata_d = '0;
        end

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cap_d[c] = cap_q[c] | det[c];
            irq_d    = irq_d | (|(cap_q[c] & mask_q[c]));

            if (ch_sel == ADDR_W'(c)) begin
                if (avs_write) begin
                    case (reg_sel)
                        REG_OUT:  out_d[c]  = wdata;
                        REG_SET:  out_d[c]  = out_q[c] | wdata;
                        REG_CLR:  out_d[c]  = out_q[c] & ~wdata;
                        // A new edge on a bit being cleared keeps it set.
                        REG_CAP:  cap_d[c]  = (cap_q[c] & ~wdata) | det[c];
                        REG_MASK: mask_d[c] = wdata;
                        REG_RISE: rise_d[c] = wdata;
                        REG_FALL: fall_d[c] = wdata;
                        default: ;
                    endcase
                end
                // Read data comes from current register values, so a
                // coincident write is not visible to the read.
                if (avs_read) begin
                    case (reg_sel)
                        REG_DATA: rdata_d[DATA_W-1:0] = sync_out[c];
                        REG_OUT:  rdata_d[DATA_W-1:0] = out_q[c];
                        REG_CAP:  rdata_d[DATA_W-1:0] = cap_q[c];
                        REG_MASK: rdata_d[DATA_W-1:0] = mask_q[c];
                        REG_RISE: rdata_d[DATA_W-1:0] = rise_q[c];
                        REG_FALL: rdata_d[DATA_W-1:0] = fall_q[c];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                out_q[c]  <= OUT_RESET;
                cap_q[c]  <= '0;
                mask_q[c] <= '0;
                rise_q[c] <= '1;
                fall_q[c] <= '0;
                prev_q[c] <= '0;
                for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[c][s] <= '0;
                end
            end
            settle_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q  <= out_d;
            cap_q  <= cap_d;
            mask_q <= mask_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                sync_q[c][0] <= in_port[c*DATA_W +: DATA_W];
                for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[c][s] <= sync_q[c][s-1];
                end
                prev_q[c] <= sync_out[c];
            end
            settle_q <= settle_d;
            rdata_q  <= rdata_d;
            rvalid_q <= avs_read;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        out_port = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            out_port[c*DATA_W +: DATA_W] = out_q[c];
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;

endmodule

// File: doc/pio_bank.md
Name: pio_bank

Overview:
- Parametrised multi-channel parallel I/O block, the successor to the fixed single 32-bit in/out port pair behind the PCIe BAR.
- Provides NUM_CH output registers and NUM_CH synchronised input ports on one Avalon-MM slave.
- Adds atomic set/clear of outputs, per-bit rising/falling edge capture and a masked, level interrupt.
- Drives the HEX displays and reads the switches/keys; later channels serve the digit-recognition datapath.

Parameters:
NUM_CH, 2, number of channels (1..8)
DATA_W, 32, bits per channel (1..32); bus is 32 bits, upper bits read 0 and are ignored on write
SYNC_STAGES, 2, input synchroniser depth (2..4)
OUT_RESET, 0, reset value of every out register (DATA_W bits)

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  synchronous reset, active low
avs_address  in  clog2(NUM_CH)+3  word address {channel, reg[2:0]}
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, fixed read latency 1
avs_readdatavalid  out  1  high the cycle after an accepted read
irq  out  1  level interrupt to the PCIe IRQ input
in_port  in  NUM_CH*DATA_W  asynchronous inputs, channel c at [c*DATA_W +: DATA_W]
out_port  out  NUM_CH*DATA_W  registered outputs, same packing

Behaviour:
- Reset (reset_n low at a clk edge) sets:
  - out = OUT_RESET; EDGE_CAP = 0; IRQ_MASK = 0; RISE_EN = all 1s; FALL_EN = 0.
  - Synchroniser and previous-value registers = 0.
  - avs_readdata = 0; avs_readdatavalid = 0; irq = 0.
  - Settle counter = 0.
- Reset mid-transaction: a pending read is dropped, and readdatavalid is low on the next cycle.
- No waitrequest: every access is accepted in the cycle it is presented.
- Per-channel register map (reg index):
  - 0 DATA: RO, synchronised input. Writes ignored.
  - 1 OUT: RW.
  - 2 OUT_SET: WO. Out |= wdata. Reads 0.
  - 3 OUT_CLR: WO. Out &= ~wdata. Reads 0.
  - 4 EDGE_CAP: R/W1C.
  - 5 IRQ_MASK: RW.
  - 6 RISE_EN: RW.
  - 7 FALL_EN: RW.
- Channel index >= NUM_CH: reads return 0 with readdatavalid still asserted; writes are ignored.
- Writes take effect on the clk edge that samples avs_write; out_port changes on that edge.
- Read:
  - Data is sampled on the edge that samples avs_read and presented with readdatavalid on the following cycle.
  - A read and a write to the same register in the same cycle return the pre-write value.
- Input path, per bit, counting the edge that first samples an in_port change as edge 1:
  - Synchroniser output, visible in DATA, updates on edge SYNC_STAGES.
  - Edge detect compares the synchroniser output with a one-cycle-delayed copy.
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - The EDGE_CAP bit sets on edge SYNC_STAGES+1.
  - irq updates on edge SYNC_STAGES+2.
- Settle counter:
  - Counts SYNC_STAGES+1 cycles after reset release.
  - Edge detection is gated off until it saturates, so inputs high at reset produce no spurious capture.
  - Counter saturates; it does not wrap.
- EDGE_CAP next value = (cap & ~w1c_mask) | detected. A W1C write coincident with a new edge on the same bit leaves the bit set (edge wins).
- Captures are sticky: further edges on a set bit have no additional effect.
- irq is registered: the OR over all channels and bits of (EDGE_CAP & IRQ_MASK).
  - Clearing the cause or the mask drops irq one edge after the write edge.
- Only DATA_W bits are stored; the writedata upper bits are discarded.

Test Plan:
- Reset then read every register of ch0, NUM_CH=2 DATA_W=32 -> OUT=0x0, RISE_EN=0xFFFFFFFF, others 0; readdatavalid exactly 1 cycle after each read; irq=0.
- Write OUT ch1=0x0000_00F0, OUT_SET 0x0000_000F, OUT_CLR 0x0000_0030 -> out_port[63:32] = 0xF0, 0xFF, 0xCF after each write edge; OUT read returns 0xCF; OUT_SET/OUT_CLR read 0.
- IRQ_MASK ch0=0x1, drive in_port[0] 0->1 -> DATA bit0=1 after 2 edges, EDGE_CAP=0x1 at edge 3, irq=1 at edge 4; W1C 0x1 -> irq=0 one edge after write; with FALL_EN=0, a 1->0 transition causes no capture.
- Hold in_port=0xFFFF_FFFF through reset release -> EDGE_CAP stays 0; a W1C write to bit 5 in the same cycle a bit5 rising edge is detected -> bit 5 remains 1.
- DATA_W=8 NUM_CH=3: write 0x1234_56AB to ch2 OUT -> out_port[23:16]=0xAB, read returns 0x0000_00AB; read of address channel 3 -> 0 with readdatavalid; write there changes nothing.
- Assert reset_n low for one cycle between an accepted read and its data cycle -> readdatavalid low, all registers at reset values.
